// File: rtl/rev_serial_squarer.sv
// rev_serial_squarer: shift-and-add squarer; one partial-product add per clock through a
// ripple chain of reversible full adders, with valid/ready on operand and result sides.
module rev_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic anc,
   output logic sum,
   output logic cout,
   output logic g1,
   output logic g2
);
   assign g1   = a;
   assign g2   = a ^ b;
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) ^ anc ^ ((a ^ b) & cin);
endmodule

module rev_serial_squarer #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_sq,
   output logic               busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   sum;
   logic [WIDTH:0]     carry;
   logic [WIDTH:0]     hi_next;
   logic [2*WIDTH:0]   acc_step;
   logic               accept, last;

   assign carry[0] = 1'b0;

   // hi[WIDTH-1:0] + opnd; the final carry becomes hi[WIDTH]
   genvar i;
   for (i = 0; i < WIDTH; i++) begin : g_fa
      rev_full_adder u_fa (
         .a    (acc_q[WIDTH+i]),
         .b    (opnd_q[i]),
         .cin  (carry[i]),
         .anc  (1'b0),
         .sum  (sum[i]),
         .cout (carry[i+1]),
         .g1   (),
         .g2   ()
      );
   end

   always_comb begin
      hi_next  = acc_q[0] ? {carry[WIDTH], sum} : acc_q[2*WIDTH:WIDTH];
      acc_step = {hi_next, acc_q[WIDTH-1:0]} >> 1;
      accept   = (state_q == IDLE) && in_valid;
      last     = (state_q == RUN) && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      state_d = accept ? RUN
              : last ? DONE
              : ((state_q == DONE) && out_ready) ? IDLE
              : state_q;
      acc_d   = accept ? {{(WIDTH+1){1'b0}}, in_a} : (state_q == RUN) ? acc_step : acc_q;
      opnd_d  = accept ? in_a : opnd_q;
      cnt_d   = accept ? '0 : (state_q == RUN) ? cnt_q + CW'(1) : cnt_q;
   end

   always_comb begin
      in_ready  = state_q == IDLE;
      out_valid = state_q == DONE;
      busy      = state_q != IDLE;
      out_sq    = out_valid ? acc_q[2*WIDTH-1:0] : '0;
   end
endmodule

// File: tb/tb_rev_serial_squarer.sv
// tb_rev_serial_squarer: scoreboard bench for the serial squarer at WIDTH=4 and WIDTH=8.
module tb_rev_serial_squarer;
   logic       clk, rst;
   logic       v, ir, ov, rdy, busy;
   logic [3:0] a;
   logic [7:0] sq;
   logic       v8, ir8, ov8, busy8;
   logic [7:0] a8;
   logic [15:0] sq8;

   int n_cmp, n_bad, n_out, cyc;
   int sb[$];
   int lat_q[$];
   logic prev_hs, prev_ov, rnd;

   rev_serial_squarer #(.WIDTH(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(v), .in_ready(ir), .in_a(a),
      .out_valid(ov), .out_ready(rdy), .out_sq(sq), .busy(busy)
   );

   rev_serial_squarer #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in_a(a8),
      .out_valid(ov8), .out_ready(1'b1), .out_sq(sq8), .busy(busy8)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge clk) if (rnd) begin
      #1;
      rdy = 1'($urandom_range(0, 1));
   end

   // result monitor: pops the scoreboard on every output handshake
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         lat_q.delete();
         prev_hs = 0;
         prev_ov = 0;
      end else begin
         if (prev_hs) chk("valid_drop", ov, 0);
         if (ov && !prev_ov && lat_q.size() != 0) chk("latency", cyc - lat_q.pop_front(), 5);
         if (ov && rdy) begin
            chk("sq", sq, sb.size() != 0 ? sb.pop_front() : 32'hDEAD_BEEF);
            n_out++;
         end
         if (v && ir) begin
            sb.push_back(int'(a) * int'(a));
            lat_q.push_back(cyc);
         end
         prev_hs = ov && rdy;
         prev_ov = ov;
      end
   end

   task automatic send(input logic [3:0] x);
      int k;
      a = x;
      v = 1;
      k = 0;
      @(negedge clk);
      while (!ir && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k == 100) chk("accept_timeout", ir, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max);
      int k;
      k = 0;
      while (sb.size() != 0 && k < max) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk("drain", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k, base;
      int vals[3] = '{0, 1, 15};
      int vals8[2] = '{255, 128};
      n_cmp = 0; n_bad = 0; n_out = 0; cyc = 0;
      rnd = 0; rst = 1; v = 0; a = 0; rdy = 1; v8 = 0; a8 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", ir, 1);
      chk("rst_out_valid", ov, 0);
      chk("rst_out_sq", sq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready8", ir8, 1);
      rst = 0;
      // reset in the middle of a run
      send(4'hB);
      v = 0;
      @(posedge clk);
      #1;
      chk("run_busy", busy, 1);
      chk("run_in_ready", ir, 0);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      chk("mid_rst_in_ready", ir, 1);
      chk("mid_rst_out_valid", ov, 0);
      chk("mid_rst_out_sq", sq, 0);
      chk("mid_rst_busy", busy, 0);
      base = n_out;
      send(4'd3);
      v = 0;
      drain(50);
      chk("t1_count", n_out - base, 1);
      // corner operands
      foreach (vals[i]) begin
         send(4'(vals[i]));
         v = 0;
         drain(50);
      end
      // long output stall
      send(4'd13);
      v = 0;
      rdy = 0;
      k = 0;
      while (!ov && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      repeat (6) begin
         chk("stall_valid", ov, 1);
         chk("stall_sq", sq, 169);
         @(posedge clk);
         #1;
      end
      rdy = 1;
      drain(50);
      // operand held during RUN must not be taken until IDLE
      base = n_out;
      send(4'd5);
      send(4'd7);
      v = 0;
      drain(50);
      chk("t4_count", n_out - base, 2);
      // exhaustive back-to-back with random sink stalls
      base = n_out;
      rnd = 1;
      for (int i = 0; i < 16; i++) send(4'(i));
      v = 0;
      drain(400);
      rnd = 0;
      @(posedge clk);
      #2;
      rdy = 1;
      chk("t5_count", n_out - base, 16);
      // WIDTH=8 instance
      foreach (vals8[i]) begin
         a8 = 8'(vals8[i]);
         v8 = 1;
         @(negedge clk);
         chk("w8_ready", ir8, 1);
         @(posedge clk);
         #1;
         v8 = 0;
         k = 0;
         while (!ov8 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
         end
         chk("w8_latency", k, 8);
         chk("w8_sq", sq8, vals8[i] * vals8[i]);
         @(posedge clk);
         #1;
         chk("w8_drop", ov8, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
